// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// A prescaler divides the clock into digit slots of SCAN_DIV cycles. The
// digit select walks 0..7, one step per slot. The first BLANK_CYCLES of each
// slot keep every anode off, so the segment lines settle on the new digit
// before its anode is switched on.
//
// Parameters
//   SCAN_DIV      clock cycles per digit slot (4 .. 2^24)
//   BLANK_CYCLES  dark cycles at the start of each slot (1 .. SCAN_DIV-2)
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_en         scan enable; low freezes the scan and darkens the display
//   i_data       nibble for the digit currently selected by o_cs
//   i_dp_mask    bit i = 1 lights the decimal point of digit i
//   i_digit_en   bit i = 0 keeps digit i dark (its slot time is still used)
//   o_cs         current digit index, 0 = rightmost
//   o_an         active-low anode enables (one-hot-low or all ones)
//   o_seg        active-low segments {dp, g, f, e, d, c, b, a}
// ---------------------------------------------------------------------------
module seg7_scan #(
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_data,
    input  logic [7:0] i_dp_mask,
    input  logic [7:0] i_digit_en,
    output logic [2:0] o_cs,
    output logic [7:0] o_an,
    output logic [7:0] o_seg
);

    localparam int                 CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_cs;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic             w_last;
    logic             w_blank;
    logic             w_lit;
    logic [7:0]       w_an_sel;
    logic [6:0]       w_dec;

    assign w_last  = (r_cnt == CNT_LAST);
    assign w_blank = (r_cnt < CNT_BLANK);

    // The anode of the current digit is driven only outside the dead-time
    // window, while scanning, and when that digit is enabled.
    assign w_lit = i_en && !w_blank && i_digit_en[r_cs];

    // One-hot-low anode pattern for the selected digit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_an_sel
            assign w_an_sel[gi] = (r_cs != 3'(gi));
        end
    endgenerate

    // Hex to active-low segments, ordered {g, f, e, d, c, b, a}.
    always_comb begin
        w_dec = 7'h7F;
        case (i_data)
            4'h0: w_dec = 7'h40;
            4'h1: w_dec = 7'h79;
            4'h2: w_dec = 7'h24;
            4'h3: w_dec = 7'h30;
            4'h4: w_dec = 7'h19;
            4'h5: w_dec = 7'h12;
            4'h6: w_dec = 7'h02;
            4'h7: w_dec = 7'h78;
            4'h8: w_dec = 7'h00;
            4'h9: w_dec = 7'h10;
            4'hA: w_dec = 7'h08;
            4'hB: w_dec = 7'h03;
            4'hC: w_dec = 7'h46;
            4'hD: w_dec = 7'h21;
            4'hE: w_dec = 7'h06;
            4'hF: w_dec = 7'h0E;
            default: w_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_cs  <= 3'd0;
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            // Outputs are computed from the pre-edge cnt/cs, so they trail
            // the scan state by one cycle. The segment register keeps
            // tracking the selected digit even while the scan is frozen.
            r_an  <= w_lit ? w_an_sel : 8'hFF;
            r_seg <= {~i_dp_mask[r_cs], w_dec};

            if (i_en) begin
                if (w_last) begin
                    r_cnt <= '0;
                    r_cs  <= r_cs + 3'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_cs  = r_cs;
    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

// File: tb/tb_seg7_scan.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan
//
// Self-checking bench for seg7_scan with SCAN_DIV=8, BLANK_CYCLES=2.
// The reference model tracks the scan as a single position counter within
// the frame (position = cs*SCAN_DIV + cnt) and derives every expected output
// from the display rules. Directed phases follow the test plan; a randomized
// phase then exercises en, rst, masks and data together.
// ---------------------------------------------------------------------------
module tb_seg7_scan;

    localparam int SD = 8;
    localparam int BL = 2;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_data;
    logic [7:0] i_dp_mask;
    logic [7:0] i_digit_en;
    logic [2:0] o_cs;
    logic [7:0] o_an;
    logic [7:0] o_seg;

    // Nibble selector: returns nibble cs of sel_word, unless overridden.
    logic [31:0] sel_word;
    logic        ov_on;
    logic [3:0]  ov_val;
    assign i_data = ov_on ? ov_val : sel_word[{o_cs, 2'b00} +: 4];

    seg7_scan #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_data     (i_data),
        .i_dp_mask  (i_dp_mask),
        .i_digit_en (i_digit_en),
        .o_cs       (o_cs),
        .o_an       (o_an),
        .o_seg      (o_seg)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc = 0;

    // Reference model state.
    int         m_t;      // position within the frame, 0 .. 8*SD-1
    logic [7:0] m_an;
    logic [7:0] m_seg;
    logic [6:0] dec_tbl [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    // One clock transaction: apply rst/en, advance the model, compare.
    task automatic cyc(input bit r, input bit e);
        int         cs;
        int         cnt;
        logic [3:0] d;
        i_rst = r;
        i_en  = e;
        cs  = m_t / SD;
        cnt = m_t % SD;
        d   = ov_on ? ov_val : sel_word[cs*4 +: 4];
        @(posedge i_clk);
        if (r) begin
            m_t   = 0;
            m_an  = 8'hFF;
            m_seg = 8'hFF;
        end else begin
            m_an  = (!e || cnt < BL || !i_digit_en[cs]) ? 8'hFF : ~(8'h01 << cs);
            m_seg = {~i_dp_mask[cs], dec_tbl[d]};
            if (e) m_t = (m_t + 1) % (8 * SD);
        end
        #1;
        n_cyc++;
        $display("cyc %0d rst=%0b en=%0b data=%h cs=%0d an=%02h seg=%02h", n_cyc, r, e, d, o_cs, o_an, o_seg);
        check("cs",  32'(o_cs),  32'(m_t / SD));
        check("an",  32'(o_an),  32'(m_an));
        check("seg", 32'(o_seg), 32'(m_seg));
    endtask

    initial begin
        dec_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        m_t = 0; m_an = 8'hFF; m_seg = 8'hFF;
        sel_word   = 32'h76543210;
        ov_on      = 1'b0;
        ov_val     = 4'h0;
        i_dp_mask  = 8'h00;
        i_digit_en = 8'hFF;
        i_rst      = 1'b1;
        i_en       = 1'b0;

        // Reset and first slot, then a full frame wrap.
        repeat (3) cyc(1'b1, 1'b1);
        check("reset_an",  32'(o_an),  32'hFF);
        check("reset_seg", 32'(o_seg), 32'hFF);
        for (int k = 1; k <= 72; k++) begin
            cyc(1'b0, 1'b1);
            if (k >= 3 && k <= 8) begin
                check("slot0_an",  32'(o_an),  32'hFE);
                check("slot0_seg", 32'(o_seg), 32'hC0);
            end
            if (k == 8) check("slot0_cs_next", 32'(o_cs), 32'd1);
        end

        // Decoder sweep through every nibble value.
        ov_on = 1'b1;
        for (int v = 0; v < 16; v++) begin
            ov_val = 4'(v);
            cyc(1'b0, 1'b1);
            check("dec_sweep", 32'(o_seg[6:0]), 32'(dec_tbl[v]));
        end
        ov_on = 1'b0;

        // Masks: digit 2 dark, its decimal point marked.
        i_dp_mask  = 8'h04;
        i_digit_en = 8'hFB;
        repeat (72) cyc(1'b0, 1'b1);
        i_dp_mask  = 8'h00;
        i_digit_en = 8'hFF;

        // Enable freeze at cnt=5, cs=3.
        for (int g = 0; g < 80 && m_t != 3*SD + 5; g++) cyc(1'b0, 1'b1);
        check("freeze_pos", 32'(m_t), 32'(3*SD + 5));
        repeat (20) cyc(1'b0, 1'b0);
        check("freeze_cs", 32'(o_cs), 32'd3);
        cyc(1'b0, 1'b1);
        check("resume_an", 32'(o_an), 32'hF7);
        repeat (2) cyc(1'b0, 1'b1);
        check("resume_cs", 32'(o_cs), 32'd4);

        // Reset mid-operation at cs=6.
        for (int g = 0; g < 80 && (m_t / SD) != 6; g++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        check("midrst_cs", 32'(o_cs), 32'd0);
        repeat (12) cyc(1'b0, 1'b1);

        // Randomized operation.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) i_dp_mask  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) i_digit_en = 8'($urandom);
            if ($urandom_range(0, 15) == 0) sel_word  = $urandom;
            ov_on  = ($urandom_range(0, 3) == 0);
            ov_val = 4'($urandom);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
